// File: rtl/poly1305_carry_if.sv
// Start/ready and operand/result bundle between the Poly1305 mulacc stage and the carry stage.
// Handshake: the master raises start for one cycle with s0..s4 stable. The slave takes the
// operands only while idle, then drops ready. When ready is high again, h0..h4 hold the new result.
interface poly1305_carry_if;
    logic        start;
    logic        ready;
    logic [63:0] s0, s1, s2, s3, s4;
    logic [31:0] h0, h1, h2, h3, h4;

    modport master (
        output start, s0, s1, s2, s3, s4,
        input  ready, h0, h1, h2, h3, h4
    );

    modport slave (
        input  start, s0, s1, s2, s3, s4,
        output ready, h0, h1, h2, h3, h4
    );
endinterface

// File: rtl/poly1305_carry.sv
// Poly1305 carry propagation: normalises five 64-bit column sums into 26-bit limbs mod 2^130-5.
// Optional macro POLY1305_CARRY_FREEZE_EN adds a second carry pass and a final freeze (h < p).
module poly1305_carry (
    input  logic                    clk,
    input  logic                    reset,
    poly1305_carry_if.slave         bus,
    output logic [3:0]              o_state
);
    // States are ordered so that every working state simply advances to the next encoding.
    typedef enum logic [3:0] {
        S_IDLE, S_CAR0, S_CAR1, S_CAR2, S_CAR3, S_CAR4, S_CAR5,
`ifdef POLY1305_CARRY_FREEZE_EN
        S_FC1, S_FC2, S_FC3, S_FC4, S_FC5, S_FSEL,
`endif
        S_DONE
    } state_t;

    localparam logic [63:0] M = 64'h0000_0000_03FF_FFFF;

    state_t      r_state;
    logic        r_ready;
    logic [63:0] r_a0, r_a1, r_a2, r_a3, r_a4;
    logic [31:0] r_h0, r_h1, r_h2, r_h3, r_h4;

`ifdef POLY1305_CARRY_FREEZE_EN
    logic [130:0] w_val;
    logic [130:0] w_g;

    // Weighted sum keeps a possible bit 26 of a1 instead of dropping it at the limb boundary.
    always_comb begin
        w_val = {67'd0, r_a0}
              + ({67'd0, r_a1} << 26)
              + ({67'd0, r_a2} << 52)
              + ({67'd0, r_a3} << 78)
              + ({67'd0, r_a4} << 104);
        w_g   = w_val + 131'd5;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_a0    <= '0;
            r_a1    <= '0;
            r_a2    <= '0;
            r_a3    <= '0;
            r_a4    <= '0;
            r_h0    <= '0;
            r_h1    <= '0;
            r_h2    <= '0;
            r_h3    <= '0;
            r_h4    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a0    <= bus.s0;
                        r_a1    <= bus.s1;
                        r_a2    <= bus.s2;
                        r_a3    <= bus.s3;
                        r_a4    <= bus.s4;
                        r_ready <= 1'b0;
                        r_state <= S_CAR0;
                    end
                end
`ifdef POLY1305_CARRY_FREEZE_EN
                S_CAR0, S_CAR5, S_FC5: begin
`else
                S_CAR0, S_CAR5: begin
`endif
                    r_a1 <= r_a1 + (r_a0 >> 26);
                    r_a0 <= r_a0 & M;
                end
`ifdef POLY1305_CARRY_FREEZE_EN
                S_CAR1, S_FC1: begin
`else
                S_CAR1: begin
`endif
                    r_a2 <= r_a2 + (r_a1 >> 26);
                    r_a1 <= r_a1 & M;
                end
`ifdef POLY1305_CARRY_FREEZE_EN
                S_CAR2, S_FC2: begin
`else
                S_CAR2: begin
`endif
                    r_a3 <= r_a3 + (r_a2 >> 26);
                    r_a2 <= r_a2 & M;
                end
`ifdef POLY1305_CARRY_FREEZE_EN
                S_CAR3, S_FC3: begin
`else
                S_CAR3: begin
`endif
                    r_a4 <= r_a4 + (r_a3 >> 26);
                    r_a3 <= r_a3 & M;
                end
`ifdef POLY1305_CARRY_FREEZE_EN
                S_CAR4, S_FC4: begin
`else
                S_CAR4: begin
`endif
                    // 2^130 == 5 mod p, so the top carry wraps into limb 0 times five.
                    r_a0 <= r_a0 + ((r_a4 >> 26) * 64'd5);
                    r_a4 <= r_a4 & M;
                end
`ifdef POLY1305_CARRY_FREEZE_EN
                S_FSEL: begin
                    if (w_g[130]) begin
                        r_a0 <= {38'd0, w_g[25:0]};
                        r_a1 <= {38'd0, w_g[51:26]};
                        r_a2 <= {38'd0, w_g[77:52]};
                        r_a3 <= {38'd0, w_g[103:78]};
                        r_a4 <= {38'd0, w_g[129:104]};
                    end
                end
`endif
                S_DONE: begin
                    r_h0    <= r_a0[31:0];
                    r_h1    <= r_a1[31:0];
                    r_h2    <= r_a2[31:0];
                    r_h3    <= r_a3[31:0];
                    r_h4    <= r_a4[31:0];
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: ;
            endcase
            if (r_state != S_IDLE && r_state != S_DONE)
                r_state <= state_t'(r_state + 4'd1);
        end
    end

    assign bus.ready = r_ready;
    assign bus.h0    = r_h0;
    assign bus.h1    = r_h1;
    assign bus.h2    = r_h2;
    assign bus.h3    = r_h3;
    assign bus.h4    = r_h4;
    assign o_state   = r_state;
endmodule

// File: tb/tb_poly1305_carry.sv
// Bench for poly1305_carry: directed limb checks, a modular scoreboard, latency, reset abort.
module tb_poly1305_carry;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] state;

    poly1305_carry_if bus();

    poly1305_carry dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .o_state (state)
    );

    always #5 clk = ~clk;

`ifdef POLY1305_CARRY_FREEZE_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 7;
`endif
    localparam logic [191:0] P = (192'd1 << 130) - 192'd5;

    logic [191:0] exp_q[$];
    int           n_tests = 0;
    int           n_fail = 0;
    logic         prev_ready = 1'b0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [191:0] limb_val(input logic [31:0] l0, l1, l2, l3, l4);
        return {160'd0, l0} + ({160'd0, l1} << 26) + ({160'd0, l2} << 52)
             + ({160'd0, l3} << 78) + ({160'd0, l4} << 104);
    endfunction

    function automatic logic [191:0] model(input logic [63:0] a0, a1, a2, a3, a4);
        logic [191:0] v;
        v = {128'd0, a0} + ({128'd0, a1} << 26) + ({128'd0, a2} << 52)
          + ({128'd0, a3} << 78) + ({128'd0, a4} << 104);
        return v % P;
    endfunction

    function automatic logic [159:0] h_vec();
        return {bus.h4, bus.h3, bus.h2, bus.h1, bus.h0};
    endfunction

    // Scoreboard: each rising ready pops one expected residue.
    always @(negedge clk) begin
        logic [191:0] e;
        logic [191:0] hv;
        logic         ok;
        if (!reset && bus.ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 1, 0);
            end else begin
                e  = exp_q.pop_front();
                hv = limb_val(bus.h0, bus.h1, bus.h2, bus.h3, bus.h4);
                check("sb_residue", hv % P, e);
`ifdef POLY1305_CARRY_FREEZE_EN
                ok = (bus.h0 < 32'h400_0000) && (bus.h1 < 32'h400_0000) && (bus.h2 < 32'h400_0000)
                  && (bus.h3 < 32'h400_0000) && (bus.h4 < 32'h400_0000) && (hv < P);
`else
                ok = (bus.h0 < 32'h400_0000) && (bus.h1 < 32'h800_0000) && (bus.h2 < 32'h400_0000)
                  && (bus.h3 < 32'h400_0000) && (bus.h4 < 32'h400_0000);
`endif
                check("sb_limb_bounds", ok, 1);
            end
        end
        prev_ready = bus.ready;
    end

    task automatic run(input logic [63:0] a0, a1, a2, a3, a4, input bit noise);
        logic [159:0] old_h;
        int           n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.s0 = a0; bus.s1 = a1; bus.s2 = a2; bus.s3 = a3; bus.s4 = a4;
        exp_q.push_back(model(a0, a1, a2, a3, a4));
        old_h = h_vec();
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("ready_drop", bus.ready, 0);
        check("h_hold", h_vec(), old_h);
        n = 0;
        while (!bus.ready && n < 40) begin
            @(posedge clk); #1;
            n++;
            bus.start = (noise && n == 3);
        end
        bus.start = 1'b0;
        check("latency", n, LAT);
    endtask

    task automatic directed(input string tag, input logic [63:0] a0, a1, a2, a3, a4,
                            input logic [159:0] exp_h, input bit noise);
        run(a0, a1, a2, a3, a4, noise);
        check(tag, h_vec(), exp_h);
    endtask

    initial begin
        logic [63:0] r[5];
        bus.start = 1'b0;
        bus.s0 = '0; bus.s1 = '0; bus.s2 = '0; bus.s3 = '0; bus.s4 = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.ready, 0);
        check("rst_h", h_vec(), 0);
        check("rst_state", state, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", bus.ready, 0);

        directed("h_zero", 0, 0, 0, 0, 0, 160'd0, 1'b0);
        directed("h_carry01", 64'h400_0000, 0, 0, 0, 0, {32'd0, 32'd0, 32'd0, 32'd1, 32'd0}, 1'b1);
        directed("h_wrap5", 0, 0, 0, 0, 64'h400_0000, {32'd0, 32'd0, 32'd0, 32'd0, 32'd5}, 1'b0);
        directed("h_multi", 64'h0010_0000_0000_0000, 0, 0, 0, 0,
                 {32'd0, 32'd0, 32'd1, 32'd0, 32'd0}, 1'b0);
`ifdef POLY1305_CARRY_FREEZE_EN
        directed("h_p", 64'h3FF_FFFB, 64'h3FF_FFFF, 64'h3FF_FFFF, 64'h3FF_FFFF, 64'h3FF_FFFF,
                 160'd0, 1'b0);
`else
        directed("h_p", 64'h3FF_FFFB, 64'h3FF_FFFF, 64'h3FF_FFFF, 64'h3FF_FFFF, 64'h3FF_FFFF,
                 {32'h3FF_FFFF, 32'h3FF_FFFF, 32'h3FF_FFFF, 32'h3FF_FFFF, 32'h3FF_FFFB}, 1'b0);
`endif
        directed("h_after_p", 64'h400_0000, 0, 0, 0, 0, {32'd0, 32'd0, 32'd0, 32'd1, 32'd0}, 1'b0);

        // Abort a run at CAR3 and confirm nothing leaks out.
        @(negedge clk);
        bus.start = 1'b1;
        bus.s0 = 64'h400_0000; bus.s1 = 0; bus.s2 = 0; bus.s3 = 0; bus.s4 = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_at_car3", state, 4);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", bus.ready, 0);
        check("abort_h", h_vec(), 0);
        check("abort_state", state, 0);
        @(negedge clk) reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_result", {bus.ready, h_vec()}, 0);

        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 5; j++)
                r[j] = {$urandom, $urandom} >> $urandom_range(2, 40);
            run(r[0], r[1], r[2], r[3], r[4], (k % 2) == 1);
        end
        run(64'h3FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF,
            64'h3FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
